nibble_add_seq: RTL and testbench

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_seq_pkg.sv | 15 +
 rtl/nibble_add_seq.sv | 141 ++++++++++++++
 tb/tb_nibble_add_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for nibble_add_seq: FSM state encoding, the nibble width
// and the latency of the external registered nibble adder.
package nibble_add_seq_pkg;

   localparam int unsigned NIB_W   = 4;  // bits per nibble
   localparam int unsigned ADD_LAT = 2;  // edges from A/B/C_in sample to SUM/C_out valid

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StAdd,
      StCapt
   } state_e;

endpackage

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: adds two NIB-nibble operands one nibble at a time through an
// external registered 4-bit adder stage, LSB nibble first, rippling the carry.
//
// Ports
//   Clock      single clock, rising edge
//   Reset      synchronous, active-high
//   start      request a new addition (sampled only when idle)
//   op_a/op_b  operands, latched on accepted start
//   carry_in   initial carry, latched on accepted start
//   A/B/C_in   registered nibble operands and carry to the adder stage
//   SUM/C_out  registered nibble sum and carry from the adder stage
//   busy       addition in progress
//   done       one-cycle pulse when result/carry_out are valid
//   result     assembled sum
//   carry_out  final carry of the full-width addition
module nibble_add_seq
   import nibble_add_seq_pkg::*;
#(
   parameter int unsigned NIB = 4
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   start,
   input  logic [NIB_W*NIB-1:0]   op_a,
   input  logic [NIB_W*NIB-1:0]   op_b,
   input  logic                   carry_in,
   output logic [NIB_W-1:0]       A,
   output logic [NIB_W-1:0]       B,
   output logic                   C_in,
   input  logic [NIB_W-1:0]       SUM,
   input  logic                   C_out,
   output logic                   busy,
   output logic                   done,
   output logic [NIB_W*NIB-1:0]   result,
   output logic                   carry_out
);

   localparam int unsigned W  = NIB_W * NIB;
   localparam int unsigned KW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [KW-1:0] KLast = KW'(NIB - 1);

   state_e            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [W-1:0]      opa_q, opa_d;
   logic [W-1:0]      opb_q, opb_d;
   logic [NIB_W-1:0]  a_q, a_d;
   logic [NIB_W-1:0]  b_q, b_d;
   logic              cin_q, cin_d;
   logic [W-1:0]      res_q, res_d;
   logic              cout_q, cout_d;
   logic              done_q, done_d;

   // Bit offsets of the nibble being captured and of the one issued next.
   int unsigned       cur_sh, nxt_sh;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      res_d   = res_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      cur_sh  = 32'(k_q) * NIB_W;
      nxt_sh  = (32'(k_q) + 32'd1) * NIB_W;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               opa_d   = op_a;
               opb_d   = op_b;
               a_d     = op_a[NIB_W-1:0];
               b_d     = op_b[NIB_W-1:0];
               cin_d   = carry_in;
               k_d     = '0;
               state_d = StIssue;
            end
         end
         // ISSUE and ADD only wait out the adder latency so CAPT sees the
         // SUM/C_out belonging to the nibble issued three edges earlier.
         StIssue: state_d = StAdd;
         StAdd:   state_d = StCapt;
         StCapt: begin
            res_d = (res_q & ~(W'({NIB_W{1'b1}}) << cur_sh)) | (W'(SUM) << cur_sh);
            if (k_q == KLast) begin
               cout_d  = C_out;
               done_d  = 1'b1;
               a_d     = '0;
               b_d     = '0;
               cin_d   = 1'b0;
               state_d = StIdle;
            end else begin
               a_d     = NIB_W'(opa_q >> nxt_sh);
               b_d     = NIB_W'(opb_q >> nxt_sh);
               cin_d   = C_out;
               k_d     = k_q + 1'b1;
               state_d = StIssue;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= StIdle;
         k_q     <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign A         = a_q;
   assign B         = b_q;
   assign C_in      = cin_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign result    = res_q;
   assign carry_out = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq with a behavioural two-stage adder model.
module tb_nibble_add_seq;

   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  op_a, op_b;
   logic          carry_in;
   logic [3:0]    a_o, b_o;
   logic          cin_o;
   logic [3:0]    sum_i;
   logic          cout_i;
   logic          busy, done;
   logic [W-1:0]  result;
   logic          carry_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nibble_add_seq #(.NIB(NIB)) dut (
      .Clock     (clk),
      .Reset     (rst),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .carry_in  (carry_in),
      .A         (a_o),
      .B         (b_o),
      .C_in      (cin_o),
      .SUM       (sum_i),
      .C_out     (cout_i),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out)
   );

   // Adder stage: samples A/B/C_in at edge E, presents SUM/C_out after E+1.
   logic [4:0] stage1;
   always @(posedge clk) begin
      stage1 <= {1'b0, a_o} + {1'b0, b_o} + {4'b0, cin_o};
      sum_i  <= stage1[3:0];
      cout_i <= stage1[4];
   end

   // Runs one addition; returns the edge count to done (-1 on timeout) and
   // A/B/C_in as seen after edge 3 (second nibble issue).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output int lat, output logic [W-1:0] res, output logic co,
                         output int busy_bad, output logic [8:0] abc3);
      @(negedge clk);
      op_a = a; op_b = b; carry_in = ci; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = -1; busy_bad = 0; res = '0; co = 1'b0; abc3 = '0;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 3) abc3 = {a_o, b_o, cin_o};
         if (done) begin
            lat = n; res = result; co = carry_out;
            if (busy) busy_bad++;
         end else if (!busy) begin
            busy_bad++;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({a_o, b_o, cin_o, busy, done, result, carry_out} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got A=%h B=%h Cin=%b busy=%b done=%b res=%h co=%b, want all 0",
                  a_o, b_o, cin_o, busy, done, result, carry_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int lat, bb; logic [W-1:0] res; logic co; logic [8:0] abc3;
      run_op(16'h1234, 16'h4321, 1'b0, lat, res, co, bb, abc3);
      total++; if (lat !== 12) begin bad++; $display("FAIL basic_latency: got %0d want 12", lat); end
      total++; if (res !== 16'h5555) begin bad++; $display("FAIL basic_result: got %h want 5555", res); end
      total++; if (co !== 1'b0) begin bad++; $display("FAIL basic_carry: got %b want 0", co); end
      total++; if (bb !== 0) begin bad++; $display("FAIL basic_busy: %0d wrong busy cycles, want 0", bb); end
      total++; if (abc3 !== {4'h3, 4'h2, 1'b0}) begin
         bad++; $display("FAIL basic_nibble1_issue: got %h want %h", abc3, {4'h3, 4'h2, 1'b0});
      end
      total++; if ({a_o, b_o, cin_o} !== 9'h0) begin
         bad++; $display("FAIL basic_adder_idle: got %h want 000", {a_o, b_o, cin_o});
      end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
      total++; if (result !== 16'h5555) begin bad++; $display("FAIL basic_hold: got %h want 5555", result); end
   endtask

   task automatic test_ripple;
      int lat, bb; logic [W-1:0] res; logic co; logic [8:0] abc3;
      run_op(16'hFFFF, 16'h0001, 1'b0, lat, res, co, bb, abc3);
      total++; if ({co, res} !== 17'h10000 || lat !== 12) begin
         bad++; $display("FAIL ripple_a: got co=%b res=%h lat=%0d want 1 0000 12", co, res, lat);
      end
      total++; if (abc3 !== {4'hF, 4'h0, 1'b1}) begin
         bad++; $display("FAIL ripple_carry_fwd: got %h want %h", abc3, {4'hF, 4'h0, 1'b1});
      end
      run_op(16'hFFFF, 16'h0000, 1'b1, lat, res, co, bb, abc3);
      total++; if ({co, res} !== 17'h10000 || lat !== 12) begin
         bad++; $display("FAIL ripple_cin: got co=%b res=%h lat=%0d want 1 0000 12", co, res, lat);
      end
      run_op(16'hA5C3, 16'h7E2D, 1'b1, lat, res, co, bb, abc3);
      total++; if ({co, res} !== 17'h123F1) begin
         bad++; $display("FAIL mixed_sum: got co=%b res=%h want 1 23F1", co, res);
      end
   endtask

   task automatic test_ignore_start;
      int dones = 0; int lat = -1; logic [W-1:0] res = '0;
      @(negedge clk);
      op_a = 16'h1234; op_b = 16'h4321; carry_in = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 24; n++) begin
         if (n == 2 || n == 5) begin
            start = 1'b1; op_a = 16'hAAAA; op_b = 16'hAAAA; carry_in = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            dones++;
            if (lat < 0) begin lat = n; res = result; end
         end
      end
      total++; if (dones !== 1 || lat !== 12) begin
         bad++; $display("FAIL ignore_done: got %0d dones first at %0d want 1 at 12", dones, lat);
      end
      total++; if (res !== 16'h5555) begin bad++; $display("FAIL ignore_result: got %h want 5555", res); end
   endtask

   task automatic test_reset_mid;
      int dones = 0; int lat, bb; logic [W-1:0] res; logic co; logic [8:0] abc3;
      @(negedge clk);
      op_a = 16'h1234; op_b = 16'h4321; carry_in = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         if (n == 6) rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (done) dones++;
      end
      total++;
      if ({a_o, b_o, cin_o, busy, done, result, carry_out} !== '0) begin
         bad++;
         $display("FAIL midreset_outputs: got A=%h B=%h Cin=%b busy=%b done=%b res=%h co=%b, want all 0",
                  a_o, b_o, cin_o, busy, done, result, carry_out);
      end
      rst = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dones++;
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", dones); end
      run_op(16'h0F0F, 16'h00F1, 1'b0, lat, res, co, bb, abc3);
      total++; if ({co, res} !== 17'h01000 || lat !== 12) begin
         bad++; $display("FAIL midreset_rerun: got co=%b res=%h lat=%0d want 0 1000 12", co, res, lat);
      end
   endtask

   task automatic test_back_to_back;
      int lat1 = -1; int lat2 = -1;
      logic [W-1:0] res1 = '0; logic [W-1:0] res2 = '0; logic co1 = 1'b0; logic co2 = 1'b0;
      @(negedge clk);
      op_a = 16'h0001; op_b = 16'h0002; carry_in = 1'b1; start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 40 && lat1 < 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            lat1 = n; res1 = result; co1 = carry_out;
            op_a = 16'h8000; op_b = 16'h8000; carry_in = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
      for (int m = 1; m <= 40 && lat2 < 0; m++) begin
         @(posedge clk);
         @(negedge clk);
         if (m == 1 && {carry_out, result} !== 17'h00004) begin
            total++; bad++;
            $display("FAIL b2b_hold: got co=%b res=%h want 0 0004", carry_out, result);
         end else if (m == 1) begin
            total++;
         end
         if (done) begin lat2 = m; res2 = result; co2 = carry_out; end
      end
      total++; if ({co1, res1} !== 17'h00004 || lat1 !== 12) begin
         bad++; $display("FAIL b2b_first: got co=%b res=%h lat=%0d want 0 0004 12", co1, res1, lat1);
      end
      total++; if ({co2, res2} !== 17'h10000 || lat2 !== 12) begin
         bad++; $display("FAIL b2b_second: got co=%b res=%h lat=%0d want 1 0000 12", co2, res2, lat2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ripple();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
